// File: rtl/ro_heater_sequencer.sv
// ro_heater_sequencer
//
// Sequences the RO heater bank. It takes a three-word heating command from the
// host stream, then plays timed heat/cool bursts into the heater's on-count and
// start-stream inputs, repeating them the requested number of times. While a
// run is active it counts the echo beats returned by the heater. At the end it
// reports that count as one status word.
//
// Command words (accepted in order):
//   W0: [7:0] heater count (clamped to MAX_RO_HEATERS), [31:16] repeat count (0 -> 1)
//   W1: ON_CYCLES
//   W2: OFF_CYCLES
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   cmd_tvalid/tdata    command stream in; cmd_tready is high in IDLE and the LOAD states
//   heat_on_num         heater count to enable (0 outside HEAT)
//   heat_tvalid/tdata   start stream to the heater (START_CODE while heating)
//   heat_tready         heater ready; informational only, never stalls
//   echo_tvalid/tdata   echo beats from the heater
//   sts_tvalid/tdata    status word {bad_echo, echo_count}, held until sts_tready
//   abort               (RO_SEQ_ABORT_EN only) ends a HEAT/COOL run early
//
// Build option: define RO_SEQ_ABORT_EN to add the abort input. Status bit 30 then
// flags an aborted run, and the echo count narrows to bits [29:0].
// All outputs are registered.

module ro_heater_sequencer #(
    parameter int unsigned MAX_RO_HEATERS = 5,
    parameter int unsigned C_DATA_WIDTH   = 32,
    parameter int unsigned START_CODE     = 1997
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_tvalid,
    input  logic [C_DATA_WIDTH-1:0] cmd_tdata,
    output logic                    cmd_tready,
    output logic [31:0]             heat_on_num,
    output logic                    heat_tvalid,
    output logic [C_DATA_WIDTH-1:0] heat_tdata,
    input  logic                    heat_tready,
    input  logic                    echo_tvalid,
    input  logic [C_DATA_WIDTH-1:0] echo_tdata,
    output logic                    sts_tvalid,
    output logic [C_DATA_WIDTH-1:0] sts_tdata,
`ifdef RO_SEQ_ABORT_EN
    input  logic                    abort,
`endif
    input  logic                    sts_tready
);

    localparam logic [C_DATA_WIDTH-1:0] StartWord = C_DATA_WIDTH'(START_CODE);
    localparam logic [7:0]              MaxNum    = 8'(MAX_RO_HEATERS);
    localparam logic [C_DATA_WIDTH-1:0] CycOne    = {{(C_DATA_WIDTH-1){1'b0}}, 1'b1};

`ifdef RO_SEQ_ABORT_EN
    // Bit 30 of the status word is taken by the abort flag.
    localparam int unsigned EchoW = C_DATA_WIDTH - 2;
`else
    localparam int unsigned EchoW = C_DATA_WIDTH - 1;
`endif
    localparam logic [EchoW-1:0] EchoOne = {{(EchoW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StLoadOn,
        StLoadOff,
        StHeat,
        StCool,
        StReport
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              num_q, num_d;
    logic [15:0]             rep_q, rep_d;
    logic [C_DATA_WIDTH-1:0] on_q, on_d;
    logic [C_DATA_WIDTH-1:0] off_q, off_d;
    logic [C_DATA_WIDTH-1:0] cyc_q, cyc_d;
    logic [EchoW-1:0]        echo_cnt_q, echo_cnt_d;
    logic                    bad_q, bad_d;
    logic                    aborted_q, aborted_d;

    logic                    cmd_tready_q, cmd_tready_d;
    logic                    heat_tvalid_q, heat_tvalid_d;
    logic [31:0]             heat_on_num_q, heat_on_num_d;
    logic [C_DATA_WIDTH-1:0] heat_tdata_q, heat_tdata_d;
    logic                    sts_tvalid_q, sts_tvalid_d;
    logic [C_DATA_WIDTH-1:0] sts_tdata_q, sts_tdata_d;

    logic                    cmd_hs;
    logic [15:0]             rep_left;
    logic                    abort_req;

    // Fields of the command words that the sequencer has no use for.
    logic unused_sig;
    assign unused_sig = ^{heat_tready, cmd_tdata[15:8]};

`ifdef RO_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign cmd_hs   = cmd_tvalid && cmd_tready_q;
    assign rep_left = rep_q - 16'd1;

    // Next state, latched command fields, counters.
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        rep_d      = rep_q;
        on_d       = on_q;
        off_d      = off_q;
        cyc_d      = cyc_q;
        echo_cnt_d = echo_cnt_q;
        bad_d      = bad_q;
        aborted_d  = aborted_q;

        // Echo monitoring covers the whole run, including the LOAD states. It is
        // frozen in REPORT so the status word stays stable while it waits.
        if (echo_tvalid && (state_q != StIdle) && (state_q != StReport)) begin
            if (echo_cnt_q != {EchoW{1'b1}}) begin
                echo_cnt_d = echo_cnt_q + EchoOne;
            end
            if (echo_tdata != StartWord) begin
                bad_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                echo_cnt_d = '0;
                bad_d      = 1'b0;
                aborted_d  = 1'b0;
                if (cmd_hs) begin
                    num_d   = (cmd_tdata[7:0] > MaxNum) ? MaxNum : cmd_tdata[7:0];
                    rep_d   = (cmd_tdata[31:16] == 16'd0) ? 16'd1 : cmd_tdata[31:16];
                    state_d = StLoadOn;
                end
            end
            StLoadOn: begin
                if (cmd_hs) begin
                    on_d    = cmd_tdata;
                    state_d = StLoadOff;
                end
            end
            StLoadOff: begin
                if (cmd_hs) begin
                    off_d = cmd_tdata;
                    if (on_q != '0) begin
                        state_d = StHeat;
                        cyc_d   = on_q;
                    end else begin
                        state_d = StCool;
                        cyc_d   = cmd_tdata;
                    end
                end
            end
            StHeat: begin
                // Counts down to 1, never through 0, so 0xFFFFFFFF cannot wrap.
                if (cyc_q > CycOne) begin
                    cyc_d = cyc_q - CycOne;
                end else begin
                    state_d = StCool;
                    cyc_d   = off_q;
                end
            end
            StCool: begin
                // A loaded value of 0 also exits here, giving one transit cycle.
                if (cyc_q > CycOne) begin
                    cyc_d = cyc_q - CycOne;
                end else begin
                    rep_d = rep_left;
                    if (rep_left == 16'd0) begin
                        state_d = StReport;
                    end else if (on_q != '0) begin
                        state_d = StHeat;
                        cyc_d   = on_q;
                    end else begin
                        state_d = StCool;
                        cyc_d   = off_q;
                    end
                end
            end
            StReport: begin
                if (sts_tready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort_req && ((state_q == StHeat) || (state_q == StCool))) begin
            state_d   = StReport;
            aborted_d = 1'b1;
        end
    end

    // Registered outputs are derived from the next state, so each output changes
    // on the same edge as the state it belongs to.
    always_comb begin
        cmd_tready_d  = (state_d == StIdle) || (state_d == StLoadOn) || (state_d == StLoadOff);
        heat_tvalid_d = (state_d == StHeat);
        heat_tdata_d  = (state_d == StHeat) ? StartWord : '0;
        heat_on_num_d = (state_d == StHeat) ? 32'(num_d) : 32'd0;
        sts_tvalid_d  = (state_d == StReport);
        sts_tdata_d   = '0;
        if (state_d == StReport) begin
`ifdef RO_SEQ_ABORT_EN
            sts_tdata_d = {bad_d, aborted_d, echo_cnt_d};
`else
            sts_tdata_d = {bad_d, echo_cnt_d};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            num_q         <= '0;
            rep_q         <= '0;
            on_q          <= '0;
            off_q         <= '0;
            cyc_q         <= '0;
            echo_cnt_q    <= '0;
            bad_q         <= 1'b0;
            aborted_q     <= 1'b0;
            cmd_tready_q  <= 1'b1;
            heat_tvalid_q <= 1'b0;
            heat_on_num_q <= '0;
            heat_tdata_q  <= '0;
            sts_tvalid_q  <= 1'b0;
            sts_tdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            num_q         <= num_d;
            rep_q         <= rep_d;
            on_q          <= on_d;
            off_q         <= off_d;
            cyc_q         <= cyc_d;
            echo_cnt_q    <= echo_cnt_d;
            bad_q         <= bad_d;
            aborted_q     <= aborted_d;
            cmd_tready_q  <= cmd_tready_d;
            heat_tvalid_q <= heat_tvalid_d;
            heat_on_num_q <= heat_on_num_d;
            heat_tdata_q  <= heat_tdata_d;
            sts_tvalid_q  <= sts_tvalid_d;
            sts_tdata_q   <= sts_tdata_d;
        end
    end

    assign cmd_tready  = cmd_tready_q;
    assign heat_tvalid = heat_tvalid_q;
    assign heat_on_num = heat_on_num_q;
    assign heat_tdata  = heat_tdata_q;
    assign sts_tvalid  = sts_tvalid_q;
    assign sts_tdata   = sts_tdata_q;

endmodule

// File: doc/ro_heater_sequencer.md
Name: ro_heater_sequencer

Overview:
- Control stage directly upstream of the RO heater bank.
- Accepts a 3-word heating command from the host-side AXI-Stream and drives the heater's on-count and start-stream inputs through timed heat/cool bursts, repeated N times.
- Counts the echo beats the heater returns, then reports that count as a single status word on an output stream.

Parameters:
- MAX_RO_HEATERS, 5, upper clamp for the heater count driven on heat_on_num.
- C_DATA_WIDTH, 32, width of every stream data bus and the cycle counters.
- START_CODE, 1997, value placed on heat_tdata while heating; the heater bank triggers on this value.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cmd_tvalid  in  1  command word valid.
- cmd_tdata  in  C_DATA_WIDTH  command word.
- cmd_tready  out  1  command word accepted when high with cmd_tvalid.
- heat_on_num  out  32  number of heaters to enable; feeds the heater's on-count input.
- heat_tvalid  out  1  start-stream valid to the heater.
- heat_tdata  out  C_DATA_WIDTH  start-stream data to the heater.
- heat_tready  in  1  heater ready. Informational only; not used to stall.
- echo_tvalid  in  1  echo beat from the heater's output stream.
- echo_tdata  in  C_DATA_WIDTH  echo data. Only non-START_CODE values are flagged.
- sts_tvalid  out  1  status word valid.
- sts_tdata  out  C_DATA_WIDTH  status word.
- sts_tready  in  1  status consumer ready.

Behaviour:
- Reset:
  - All outputs are 0, except cmd_tready = 1.
  - State is IDLE; all counters and registers are cleared.
  - Reset mid-operation aborts immediately; heat_tvalid falls on the cycle after rst is sampled.
- Command format, three beats accepted in order:
  - W0: [7:0] heater count; [31:16] repeat count. Repeat 0 is treated as 1.
  - W1: ON_CYCLES.
  - W2: OFF_CYCLES.
- Command loading:
  - cmd_tready = 1 only in IDLE, LOAD_ON and LOAD_OFF.
  - A heater count above MAX_RO_HEATERS is clamped to MAX_RO_HEATERS.
- States:
  - IDLE: on W0 handshake, latch count and repeats -> LOAD_ON.
  - LOAD_ON: on W1 handshake, latch ON -> LOAD_OFF.
  - LOAD_OFF: on W2 handshake, latch OFF. Go to HEAT if ON != 0; otherwise go to COOL.
  - HEAT:
    - Outputs: heat_tvalid = 1, heat_tdata = START_CODE, heat_on_num = latched count.
    - Stays exactly ON cycles, then -> COOL.
  - COOL:
    - Outputs: heat_tvalid = 0, heat_tdata = 0, heat_on_num = 0.
    - Stays exactly OFF cycles; OFF = 0 gives one transit cycle.
    - Then decrement repeats. If the remaining count is nonzero, go to HEAT (or COOL again if ON = 0); otherwise -> REPORT.
  - REPORT:
    - Outputs: sts_tvalid = 1, sts_tdata = {bad_echo flag in bit 31, echo_count[30:0]}.
    - Held stable until sts_tready; on handshake -> IDLE, and counters clear on entry to IDLE.
- Registered outputs: all outputs come from registers, so heat_tvalid rises one cycle after the W2 handshake.
- Echo monitoring:
  - echo_count increments on each echo_tvalid cycle, in any state except IDLE and REPORT.
  - echo_count saturates at 2^31-1 and does not wrap.
  - bad_echo sets, and stays set, if echo_tvalid arrives with echo_tdata != START_CODE.
- Cycle counter:
  - Width C_DATA_WIDTH; loaded with ON or OFF on state entry and decremented to 1.
  - An ON or OFF value of 0xFFFFFFFF must not wrap.
- Ignored traffic: commands presented during HEAT, COOL or REPORT are not accepted (cmd_tready = 0).

Optional Feature:
- Macro: RO_SEQ_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort = 1 in HEAT or COOL forces REPORT on the next cycle; heat_tvalid and heat_on_num drop to 0 on that same cycle.
  - Status bit 30 is set to 1, marking an aborted run, and echo_count is then limited to [29:0].
  - abort is ignored in IDLE, the LOAD states and REPORT.
- When undefined: no abort port; bit 30 is part of echo_count.

Test Plan:
- W0 = 0x0001_0003, W1 = 10, W2 = 5, sts_tready = 1, heater echo looped back:
  - heat_on_num = 3 and heat_tvalid = 1 for exactly 10 cycles, then 0 for 5 cycles.
  - One status word = echo beats counted, bit 31 = 0.
- W0 = 0x0002_0009, W1 = 4, W2 = 2:
  - Count clamped, so heat_on_num = 5.
  - Two HEAT bursts of 4 cycles each, separated by 2 cool cycles; one status word.
- W1 = 0, W2 = 3, repeat 1: heat_tvalid never asserts; status word = 0 after 3 cool cycles.
- Inject echo_tdata = 7 during HEAT: status bit 31 = 1. Hold sts_tready = 0 for 20 cycles: sts_tdata remains stable and cmd_tready stays 0.
- Assert rst for 1 cycle mid-HEAT: next cycle heat_tvalid = 0, cmd_tready = 1, sts_tvalid = 0; a fresh command then runs normally.
- RO_SEQ_ABORT_EN: pulse abort 3 cycles into a 100-cycle HEAT -> REPORT next cycle with status bit 30 = 1.
